// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared sizing helpers and types for the CIC decimator
package cic_pkg;

  localparam int DEF_N_STAGES = 3;
  localparam int DEF_DECIM    = 64;

  // Worst-case growth of N stages at ratio R, plus sign and headroom bits.
  function automatic int acc_width(input int n, input int r);
    return n * $clog2(r) + 2;
  endfunction

  typedef logic [acc_width(DEF_N_STAGES, DEF_DECIM)-1:0] acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one registered comb section: y = x - x[-1] at the decimated rate
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int WIDTH = acc_width(DEF_N_STAGES, DEF_DECIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] delay_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        // Modulo subtraction undoes integrator wrap-around exactly.
        data_out <= data_in - delay_q;
        delay_q  <= data_in;
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator turning a 1-bit DSM stream into signed PCM
module cic_decimator
  import cic_pkg::*;
#(
  parameter int N_STAGES  = 3,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        dsm_in,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid
);

  localparam int ACC_WIDTH = acc_width(N_STAGES, DECIM);
  localparam int CNT_W     = $clog2(DECIM);
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM - 1);

  if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_width
    $error("cic_decimator: OUT_WIDTH exceeds ACC_WIDTH");
  end

  // 1 -> +1, 0 -> -1, already sign-extended.
  logic [ACC_WIDTH-1:0] x;
  assign x = {{(ACC_WIDTH-1){~dsm_in}}, 1'b1};

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_in;
    if (k == 0) begin : g_first
      assign acc_in = x;
    end else begin : g_chain
      assign acc_in = g_int[k-1].acc;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc <= '0;
      end else if (clk_en) begin
        acc <= acc + acc_in;
      end
    end
  end

  logic [CNT_W-1:0] dec_cnt;
  logic             dec_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
      dec_stb <= 1'b0;
    end else begin
      dec_stb <= 1'b0;
      if (clk_en) begin
        if (dec_cnt == CNT_MAX) begin
          dec_cnt <= '0;
          dec_stb <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt + CNT_W'(1);
        end
      end
    end
  end

  // The first comb samples I_N while dec_stb is high, so the frame's last input is included.
  logic [N_STAGES:0][ACC_WIDTH-1:0] comb_data;
  logic [N_STAGES:0]                comb_valid;

  assign comb_data[0]  = g_int[N_STAGES-1].acc;
  assign comb_valid[0] = dec_stb;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    cic_comb_stage #(.WIDTH(ACC_WIDTH)) u_comb (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (comb_valid[k]),
      .data_in   (comb_data[k]),
      .valid_out (comb_valid[k+1]),
      .data_out  (comb_data[k+1])
    );
  end

  if (SHIFT > 0) begin : g_lsb
    logic unused_lsbs;
    assign unused_lsbs = ^comb_data[N_STAGES][SHIFT-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= comb_valid[N_STAGES];
      if (comb_valid[N_STAGES]) begin
        out <= comb_data[N_STAGES][ACC_WIDTH-1 -: OUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - directed self-checking bench for cic_decimator at default parameters
module tb_cic_decimator;
  import cic_pkg::*;

  logic               clk;
  logic               rst;
  logic               clk_en;
  logic               dsm_in;
  logic signed [15:0] out;
  logic               out_valid;

  int n_assert = 0;
  int n_fail   = 0;

  cic_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .dsm_in    (dsm_in),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic d, input logic en);
    dsm_in = d;
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // Drives a repeating pattern (bit s%plen at sample s), clk_en every div clocks.
  task automatic run_case(input string tag, input logic [3:0] pat, input int plen,
                          input int div, input int npulses, input int exp_out);
    int   c     = 0;
    int   s     = 0;
    int   pulse = 0;
    int   last  = 0;
    acc_t sum   = '0;
    logic d;
    logic en;
    while (pulse < npulses && c < npulses * 64 * div + 200) begin
      en = ((c % div) == 0);
      d  = pat[s % plen];
      tick(d, en);
      c++;
      if (en) begin
        s++;
        sum = d ? sum + acc_t'(1) : sum - acc_t'(1);
      end
      if (div > 1 && (c % div) == 50)
        check({tag, "_int_hold"}, 32'(dut.g_int[0].acc), 32'(sum));
      if (out_valid) begin
        pulse++;
        if (pulse == 1) check({tag, "_first_edge"}, c, 63 * div + 5);
        else            check({tag, "_spacing"}, c - last, 64 * div);
        last = c;
        if (pulse >= 3) check({tag, "_out"}, out, exp_out);
      end
    end
    check({tag, "_pulses"}, pulse, npulses);
  endtask

  initial begin
    rst    = 1'b0;
    clk_en = 1'b0;
    dsm_in = 1'b0;

    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      check("rst_hold", {out_valid, out}, 0);
    end
    rst = 1'b1;

    run_case("ones",  4'b1111, 1, 1, 5, 16384);
    do_reset();
    run_case("zeros", 4'b0000, 1, 1, 4, -16384);
    do_reset();
    run_case("alt",   4'b0101, 2, 1, 4, 0);
    do_reset();
    run_case("p1110", 4'b0111, 4, 1, 4, 8192);
    do_reset();
    run_case("gated", 4'b1111, 1, 100, 4, 16384);

    // Asynchronous reset in the middle of frame 4, off the clock edge.
    do_reset();
    for (int i = 0; i < 222; i++) tick(1'b1, 1'b1);
    check("mid_cnt", 32'(dut.dec_cnt), 30);
    check("mid_out", out, 16384);
    #3;
    rst = 1'b0;
    #1;
    check("async_out",  {out_valid, out}, 0);
    check("async_cnt",  32'(dut.dec_cnt), 0);
    check("async_int1", 32'(dut.g_int[0].acc), 0);
    check("async_int3", 32'(dut.g_int[2].acc), 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    check("async_hold", 32'(dut.g_int[0].acc), 0);
    rst = 1'b1;
    run_case("post_rst", 4'b1111, 1, 1, 3, 16384);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Third-order (default) CIC decimation filter that consumes the 1-bit bitstream of first_order_dsm_dac / second_order_dsm_dac.
- Reconstructs a multi-bit signed PCM sample stream at 1/DECIM of the bitstream rate.
- Used in-bench and on-chip to close the loop sin_gen_zoh -> dsm_dac -> cic_decimator, so the recovered waveform can be compared against the source.

Parameters:
- N_STAGES, 3, number of integrator and comb stages (1..5).
- DECIM, 64, decimation ratio R (2..1024, any integer, not restricted to powers of two).
- OUT_WIDTH, 16, output sample width, signed; must satisfy OUT_WIDTH <= ACC_WIDTH (elaboration-time $error otherwise).
- ACC_WIDTH (localparam), N_STAGES*$clog2(DECIM)+2, internal two's-complement width; 20 at defaults.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- clk_en  in  1  bitstream sample strobe; dsm_in is consumed on clk edges where clk_en=1.
- dsm_in  in  1  DSM bitstream; 1 -> +1, 0 -> -1.
- out  out  OUT_WIDTH  signed decimated sample; held between updates.
- out_valid  out  1  one-cycle pulse when out updates.

Behaviour:
- Reset (rst=0, async): all integrators, combs, delay registers, decimation counter, pipeline valids, out and out_valid cleared to 0. Release is synchronous to clk.
- Input map: x = dsm_in ? +1 : -1, sign-extended to ACC_WIDTH.
- Integrators: on clk_en=1, I1 += x and Ik += I(k-1) for k = 2..N, all updating in the same edge (chained registers). Wrap-around modulo 2^ACC_WIDTH is intended and correct (CIC property); no saturation.
- When clk_en=0, the integrators and the counter hold.
- Decimation counter: 0..DECIM-1, advances on clk_en. On a clk_en edge with counter = DECIM-1, the counter wraps to 0 and dec_stb is registered high for exactly one cycle.
- While dec_stb=1, I_N is captured into the comb input register; this value includes the frame's last sample.
- Combs: pipelined, one registered stage per cycle. Stage k computes y_k = y_(k-1) - d_k, then d_k <= y_(k-1), only when its valid bit is set. The valid bit shifts every clk regardless of clk_en.
- Comb subtraction is modulo 2^ACC_WIDTH.
- Output: out <= arithmetic right shift of the final comb by (ACC_WIDTH-OUT_WIDTH), i.e. the top OUT_WIDTH bits (truncation, no rounding). out_valid pulses the same cycle.
- Latency: out_valid rises N_STAGES+1 cycles after the clk edge that sampled the frame's last dsm_in.
- Throughput: one output per DECIM accepted samples. The pipeline depth N_STAGES+1 is less than DECIM, so no overlap or back-pressure is possible.
- DC gain: DECIM^N_STAGES. For an all-ones input, the final comb value is +2^18 at defaults and out = +16384; all-zeros gives -16384.
- Settling: output k (1-based) is exact once k >= N_STAGES.
- Reset mid-frame: all state is discarded, and the first post-reset output again needs DECIM fresh samples.
- clk_en held continuously high (clk_en tied to clk-rate, as the DACs run): valid, one sample per cycle.
- clk_en low on the wrap cycle: the wrap is deferred to the next clk_en.

Decomposition:
- Package cic_pkg: acc_width(n, r) constant function, plus typedef acc_t sized to ACC_WIDTH for the default configuration.
- Module-local logic [ACC_WIDTH-1:0] for parameterised use.
- One natural sub-module, cic_comb_stage: a registered subtract with delay, and valid-in/valid-out.
- Integrators stay inline in a generate loop.

Test Plan:
- Reset: hold rst=0 with random dsm_in and clk_en=1 for 200 cycles -> out=0 and out_valid=0 throughout. Release, drive all-ones -> first out_valid exactly 64+4-1 edges after release of sampling (frame-last sample edge + 4).
- DC full-scale: dsm_in=1, clk_en=1 continuously -> out_valid every 64 cycles; out = +16384 from the 3rd pulse onward. Repeat with dsm_in=0 -> -16384.
- Mid-scale: alternating 1,0,1,0 -> out = 0 from the 3rd pulse onward. Pattern 1,1,1,0 (mean +0.5) -> out = +8192.
- clk_en gating: clk_en from clk_div DIV=100, dsm_in=1 -> out_valid every 6400 clks, out = +16384 steady. Integrators hold between strobes; check via a hierarchical probe.
- Async reset mid-frame: assert rst=0 for 3 cycles at counter = 30, without aligning to clk -> all state 0 immediately. Next out_valid comes 64 samples after release.
- Closed loop: sin_gen_zoh -> second_order_dsm_dac (clk_en=clk) -> cic_decimator -> decoded sine frequency matches the source. Peak within ±2% of the expected scaled amplitude, no wrap glitches over 100000 cycles.
